// File: rtl/prog_counter_if.sv
// Control and status bundle for prog_counter.
// The master side drives the control inputs; the slave side (the counter)
// returns the count value and the terminal-event status.
interface prog_counter_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             enable;
    logic             up_dn;
    logic [WIDTH-1:0] term_val;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data_out;
    logic             term_pulse;
    logic             term_flag;
    logic             busy;

    modport master (
        output clear, load, data_in, enable, up_dn, term_val, mode,
        input  data_out, term_pulse, term_flag, busy
    );

    modport slave (
        input  clear, load, data_in, enable, up_dn, term_val, mode,
        output data_out, term_pulse, term_flag, busy
    );
endinterface

// File: rtl/prog_counter.sv
// Programmable up/down counter with a terminal value and three step modes:
// wrap, saturate and one-shot. It raises a single-cycle terminal strobe, a
// sticky terminal flag and a busy indication while a one-shot run is active.
module prog_counter #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          async_rst,
    prog_counter_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0]       MODE_SAT     = 2'b01;
    localparam logic [1:0]       MODE_ONESHOT = 2'b10;
    localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             term_pulse_q, term_pulse_d;
    logic             term_flag_q, term_flag_d;
    state_t           state_q, state_d;

    logic [WIDTH-1:0] boundary;
    logic [WIDTH-1:0] step_val;
    logic             at_boundary;
    logic             is_sat;
    logic             is_oneshot;

    // Boundary and candidate step are evaluated on the current count and the
    // live inputs, so direction/terminal/mode changes act on the next edge.
    always_comb begin
        boundary    = bus.up_dn ? bus.term_val : '0;
        step_val    = bus.up_dn ? (count_q + ONE) : (count_q - ONE);
        at_boundary = (count_q == boundary);
        is_sat      = (bus.mode == MODE_SAT);
        is_oneshot  = (bus.mode == MODE_ONESHOT);
    end

    // Next-state selection with priority clear > load > enable > hold.
    always_comb begin
        count_d      = count_q;
        term_pulse_d = 1'b0;
        state_d      = state_q;

        // A run is only meaningful in one-shot mode; leaving that mode ends
        // it on this edge while counting follows the new mode.
        if (!is_oneshot) begin
            state_d = IDLE;
        end

        if (bus.clear) begin
            count_d = '0;
            state_d = IDLE;
        end else if (bus.load) begin
            count_d = bus.data_in;
            if (is_oneshot) begin
                state_d = RUN;
            end
        end else if (bus.enable) begin
            if (is_sat || (is_oneshot && state_q == RUN)) begin
                // Saturating step; in one-shot a run already sitting on the
                // boundary completes on this step with the count held.
                if (at_boundary) begin
                    if (is_oneshot) begin
                        term_pulse_d = 1'b1;
                        state_d      = IDLE;
                    end
                end else begin
                    count_d = step_val;
                    if (step_val == boundary) begin
                        term_pulse_d = 1'b1;
                        if (is_oneshot) begin
                            state_d = IDLE;
                        end
                    end
                end
            end else if (!is_oneshot) begin
                // Wrap (modes 00 and 11): leaving the boundary reloads the
                // opposite end and raises the event.
                if (at_boundary) begin
                    count_d      = bus.up_dn ? '0 : bus.term_val;
                    term_pulse_d = 1'b1;
                end else begin
                    count_d = step_val;
                end
            end
        end

        term_flag_d = bus.clear ? 1'b0 : (term_flag_q | term_pulse_d);
    end

    // State and output registers; reset is asynchronous and forces idle.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            count_q      <= '0;
            term_pulse_q <= 1'b0;
            term_flag_q  <= 1'b0;
            state_q      <= IDLE;
        end else begin
            count_q      <= count_d;
            term_pulse_q <= term_pulse_d;
            term_flag_q  <= term_flag_d;
            state_q      <= state_d;
        end
    end

    assign bus.data_out   = count_q;
    assign bus.term_pulse = term_pulse_q;
    assign bus.term_flag  = term_flag_q;
    assign bus.busy       = (state_q == RUN);

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter: WIDTH, 8, counter and terminal-value width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge except reset.
REQ-003 Port: async_rst  input  1  asynchronous, active-high reset.
REQ-004 Port: clear  input  1  synchronous clear of count and term_flag.
REQ-005 Port: load  input  1  synchronous load of data_in; also arms one-shot mode.
REQ-006 Port: data_in  input  WIDTH  load value.
REQ-007 Port: enable  input  1  count-step request.
REQ-008 Port: up_dn  input  1  step direction: 1 = increment, 0 = decrement.
REQ-009 Port: term_val  input  WIDTH  programmable terminal value T.
REQ-010 Port: mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as 00.
REQ-011 Port: data_out  output  WIDTH  registered count value.
REQ-012 Port: term_pulse  output  1  registered single-cycle terminal-event strobe.
REQ-013 Port: term_flag  output  1  sticky copy of term_pulse.
REQ-014 Port: busy  output  1  one-shot run in progress.

Function
REQ-015 Per-edge priority SHALL be clear > load > enable > hold.
REQ-016 clear SHALL set data_out = 0, term_flag = 0, term_pulse = 0, and state IDLE.
REQ-017 load SHALL set data_out = data_in and term_pulse = 0; with mode = 10 it SHALL also enter state RUN (busy = 1); otherwise it SHALL leave the state unchanged.
REQ-018 The boundary SHALL be T when up_dn = 1 and 0 when up_dn = 0; the comparison SHALL be equality on the current data_out.
REQ-019 Wrap mode: an enabled step at the boundary SHALL move data_out to 0 (up) or T (down) and assert term_pulse on the same edge.
REQ-020 Wrap mode: an enabled step off the boundary SHALL apply +1/-1 modulo 2^WIDTH, with term_pulse = 0.
REQ-021 Saturate mode: an enabled step whose result equals the boundary SHALL assert term_pulse.
REQ-022 Saturate mode: an enabled step while already at the boundary SHALL hold data_out, with term_pulse = 0.
REQ-023 One-shot mode, state IDLE: enable SHALL be ignored; data_out holds.
REQ-024 One-shot mode, state RUN: steps SHALL be as in saturate mode; on the step that reaches the boundary, term_pulse = 1, the state SHALL return to IDLE and busy SHALL fall on that same edge.
REQ-025 A load in state RUN with mode = 10 SHALL restart the run from data_in.
REQ-026 A load value already at the boundary in one-shot mode SHALL still enter RUN; the next enabled step SHALL then complete the run per REQ-024, with data_out held and term_pulse = 1.
REQ-027 If mode leaves 10 while in RUN, the state SHALL return to IDLE (busy = 0) on the next edge, and counting SHALL follow the new mode on that same edge.
REQ-028 term_pulse SHALL be high for exactly one cycle per terminal event; with enable held, consecutive events MAY produce consecutive pulses.
REQ-029 term_flag SHALL set on any cycle term_pulse = 1 and clear only by clear or async_rst.
REQ-030 A data_out above T while counting up SHALL count through 2^WIDTH-1, wrap naturally to 0, and then reach T; no event SHALL be generated at the natural wrap.
REQ-031 T = 0 with up_dn = 1 in wrap mode SHALL hold data_out = 0 and pulse on every enabled cycle.
REQ-032 term_val, up_dn and mode changes SHALL take effect on the next edge with no internal pipelining.

Reset
REQ-033 async_rst high SHALL immediately, without clk, force data_out = 0, term_pulse = 0, term_flag = 0, busy = 0, state IDLE.
REQ-034 All outputs SHALL hold these values while async_rst is high, regardless of other inputs.
REQ-035 Deassertion of async_rst SHALL allow normal operation from the first following clk edge.
REQ-036 Reset asserted mid-run SHALL abort the run with no term_pulse.

Verification (WIDTH = 8)
REQ-037 Wrap up, T = 7, enable held from reset -> data_out 0..7, then 0, with term_pulse on the 7->0 edge every 8 cycles and term_flag set.
REQ-038 Wrap down, T = 5, load 2 -> data_out 2,1,0,5,4, with a pulse on the 0->5 edge.
REQ-039 Saturate up, T = 3, from 0 -> data_out 1,2,3,3,3, with exactly one pulse on the 2->3 edge.
REQ-040 One-shot, T = 4, load 1 -> busy = 1, data_out 2,3,4; pulse and busy fall together; further enable keeps data_out = 4, busy = 0, and term_pulse stays 0.
REQ-041 Simultaneous clear, load and enable -> data_out = 0 and term_flag = 0; load and enable alone -> data_out = data_in, with no increment.
REQ-042 async_rst pulsed between clk edges during a one-shot at data_out = 3 -> all outputs 0 immediately, no pulse, and counting resumes from 0 after release.
